uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  8N1 UART receiver for the debug link. Recovers bytes from the host serial
//  line (rx) and holds each one in a single-entry buffer with a valid/ready
//  handshake. Feeds the debug command path that drives halt/step. It is the
//  receive-side counterpart to the debug transmitter's uart_tx.
// PARAMETERS
//  CLKS_PER_BIT  104  clk cycles per bit; 104 = 115200 baud at 12 MHz; must be >= 8
// PORTS
//  clk        in   1  system clock (12 MHz nominal); all logic on rising edge
//  reset_n    in   1  asynchronous, active-low reset
//  rx         in   1  serial input, idle high, asynchronous to clk
//  data       out  8  received byte, LSB first on the wire; stable while valid=1
//  valid      out  1  data holds an unconsumed byte
//  ready      in   1  consumer accepts data when valid && ready
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  overrun    out  1  sticky: a byte completed while buffer was full; cleared on accept
//  busy       out  1  1 while the FSM is in any state other than IDLE
// BEHAVIOUR
//  Reset: data=8'h00, valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE.
//   The synchronizer flops reset to 1.
//  Sync: rx passes through a 2-FF synchronizer (rx_s), which adds 2 cycles of
//   latency. All decisions use rx_s only.
//  Counters: clk_cnt is clog2(CLKS_PER_BIT) bits wide; bit_idx is 3 bits.
//  FSM states:
//   IDLE : busy=0. When rx_s=0: clk_cnt<=0, go to START.
//   START: on clk_cnt==CLKS_PER_BIT/2-1, check rx_s.
//          rx_s=1 (glitch): go to IDLE, no output.
//          rx_s=0: clk_cnt<=0, bit_idx<=0, go to DATA.
//          Otherwise clk_cnt++.
//   DATA : on clk_cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx] and
//          clear clk_cnt. When bit_idx==7, go to STOP; otherwise bit_idx++.
//   STOP : on clk_cnt==CLKS_PER_BIT-1, sample rx_s.
//          rx_s=1: deliver shreg (rules below).
//          rx_s=0: frame_err pulses for 1 cycle and the byte is discarded.
//          Both cases go to IDLE next cycle.
//  Delivery:
//   - valid=0, or accept in this same cycle: data<=shreg, valid<=1.
//   - valid=1 and no accept: data is kept (the new byte is dropped), overrun<=1.
//  Handshake:
//   - valid && ready clears valid next cycle.
//   - Accept plus delivery in the same cycle: valid stays 1 with the new data.
//   - ready while valid=0 has no effect.
//   - data never changes while valid=1, except on an accept+deliver cycle.
//  Timing: valid rises about 9.5 bit times + 3 cycles after the start edge.
//   IDLE is re-entered mid stop-bit, so a back-to-back start bit is caught.
//  Line held low (break): yields frame_err once, then the FSM waits in IDLE
//   and restarts only on the next 1->0 edge. A start_ok flag requires rx_s=1
//   to be seen in IDLE before a new start is accepted.
//  Reset asserted mid-frame: the partial byte is lost and all outputs return
//   to reset values immediately.
// TESTING
//  1. Send 8'hA5 at CLKS_PER_BIT=104, ready=1 -> valid pulses 1 cycle,
//     data=8'hA5, frame_err=0.
//  2. Send 8'h00 then 8'hFF back-to-back, ready=0 -> data=8'h00 held, valid=1,
//     overrun=1. Pulse ready -> valid=0, overrun=0.
//  3. Hold rx low for 30 cycles, then high -> no valid, FSM back in IDLE,
//     busy=0 within 53 cycles.
//  4. Send 8'h3C with stop bit driven 0 -> frame_err 1-cycle pulse, valid stays 0.
//     Then hold rx=1 and send 8'h3C normally -> data=8'h3C.
//  5. Assert reset_n=0 midway through bit 4 of 8'h81 -> outputs at reset values.
//     After release, send 8'h81 -> data=8'h81.
//  6. Send 8'h55 with bit period +/-3% (101/107 cycles) -> data=8'h55, no frame_err.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a single-entry output buffer and valid/ready handshake.
// Samples each bit mid-period from a 2-FF synchronised copy of the line.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   clk_cnt, clk_cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shreg, shreg_next;
  logic            start_ok, start_ok_next;
  logic            deliver, stop_bad, accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      start_ok <= 1'b0;
    end else begin
      state    <= state_next;
      clk_cnt  <= clk_cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      start_ok <= start_ok_next;
    end
  end

  // start_ok blocks a held-low (break) line from retriggering until it idles high
  always_comb begin
    state_next    = state;
    clk_cnt_next  = clk_cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    start_ok_next = start_ok;
    deliver       = 1'b0;
    stop_bad      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_s) begin
          start_ok_next = 1'b1;
        end else if (start_ok) begin
          clk_cnt_next  = '0;
          start_ok_next = 1'b0;
          state_next    = START;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            clk_cnt_next = '0;
            bit_idx_next = '0;
            state_next   = DATA;
          end
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          shreg_next[bit_idx] = rx_s;
          clk_cnt_next        = '0;
          if (bit_idx == 3'd7) state_next = STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt == BIT_LAST) begin
          if (rx_s) deliver = 1'b1;
          else stop_bad = 1'b1;
          clk_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          clk_cnt_next = clk_cnt + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = valid && ready;
  assign busy   = (state != IDLE);

  // A completed byte only lands if the buffer is empty or draining this cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      if (deliver && (!valid || ready)) begin
        data  <= shreg;
        valid <= 1'b1;
      end else if (accept) begin
        valid <= 1'b0;
      end
      if (accept) overrun <= 1'b0;
      else if (deliver && valid) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, directed corner cases
// and randomized frames checked against an expected-byte queue.
module tb_uart_rx;

  localparam int CPB = 104;

  logic       clk;
  logic       reset_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks;
  int failures;

  logic [7:0] obs_q[$];
  int         ferr_cnt;

  typedef struct {
    logic [7:0] value;
    int         period;
    logic       stop_bit;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed deliveries and framing errors, sampled away from the active edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid && ready) obs_q.push_back(data);
      if (frame_err) ferr_cnt++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int period);
    rx = v;
    wait_cycles(period);
  endtask

  task automatic send_byte(input logic [7:0] b, input int period, input logic stop_bit);
    drive_bit(1'b0, period);
    for (int i = 0; i < 8; i++) drive_bit(b[i], period);
    drive_bit(stop_bit, period);
    rx = 1'b1;
  endtask

  // Reference: a good stop bit yields exactly that byte, a bad one a single frame_err
  task automatic apply_stimulus(input string name, input logic [7:0] value, input int period,
                                input logic stop_bit, input logic exp_valid, input logic exp_ferr,
                                input int gap);
    int obs_before;
    int ferr_before;
    obs_before  = obs_q.size();
    ferr_before = ferr_cnt;
    send_byte(value, period, stop_bit);
    check_output({name, "_count"}, obs_q.size() - obs_before, 32'(exp_valid));
    if (exp_valid && obs_q.size() > obs_before)
      check_output({name, "_data"}, obs_q[$], value);
    check_output({name, "_ferr"}, ferr_cnt - ferr_before, 32'(exp_ferr));
    check_output({name, "_overrun"}, overrun, 0);
    wait_cycles(gap);
  endtask

  initial begin
    int obs_before;
    int ferr_before;
    int waited;
    logic [7:0] rb;
    int         rp;
    logic       rs;

    checks   = 0;
    failures = 0;
    ferr_cnt = 0;

    vecs[0] = '{8'hA5, 104, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'h55, 101, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 107, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 104, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h3C, 104, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h81, 104, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'h00, 104, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{8'hFF, 104, 1'b1, 1'b1, 1'b0};

    reset_n = 1'b0;
    rx      = 1'b1;
    ready   = 1'b1;
    wait_cycles(5);
    check_output("rst_data", data, 8'h00);
    check_output("rst_valid", valid, 0);
    check_output("rst_ferr", frame_err, 0);
    check_output("rst_overrun", overrun, 0);
    check_output("rst_busy", busy, 0);
    reset_n = 1'b1;
    wait_cycles(10);

    for (int i = 0; i < 8; i++)
      apply_stimulus($sformatf("vec%0d", i), vecs[i].value, vecs[i].period, vecs[i].stop_bit,
                     vecs[i].exp_valid, vecs[i].exp_ferr, 8);

    // Back-to-back bytes into a full buffer
    ready = 1'b0;
    wait_cycles(2);
    send_byte(8'h00, CPB, 1'b1);
    send_byte(8'hFF, CPB, 1'b1);
    wait_cycles(4);
    check_output("ovr_valid", valid, 1);
    check_output("ovr_data", data, 8'h00);
    check_output("ovr_flag", overrun, 1);
    obs_before = obs_q.size();
    ready = 1'b1;
    wait_cycles(1);
    ready = 1'b0;
    check_output("ovr_accept_count", obs_q.size() - obs_before, 1);
    check_output("ovr_accept_data", (obs_q.size() > 0) ? obs_q[$] : 8'hXX, 8'h00);
    check_output("ovr_valid_clr", valid, 0);
    check_output("ovr_flag_clr", overrun, 0);
    wait_cycles(3);
    check_output("ready_idle_valid", valid, 0);
    ready = 1'b1;
    wait_cycles(4);

    // Short low pulse: START rejects it as a glitch
    obs_before  = obs_q.size();
    ferr_before = ferr_cnt;
    rx = 1'b0;
    wait_cycles(5);
    check_output("glitch_busy", busy, 1);
    wait_cycles(25);
    rx = 1'b1;
    waited = 0;
    while (busy && waited < 60) begin
      wait_cycles(1);
      waited++;
    end
    check_output("glitch_idle", busy, 0);
    check_output("glitch_no_valid", obs_q.size() - obs_before, 0);
    check_output("glitch_no_ferr", ferr_cnt - ferr_before, 0);
    wait_cycles(10);

    // Break: line held low well past a frame gives one frame_err, no restart
    ferr_before = ferr_cnt;
    obs_before  = obs_q.size();
    rx = 1'b0;
    wait_cycles(CPB * 14);
    check_output("break_ferr", ferr_cnt - ferr_before, 1);
    check_output("break_idle", busy, 0);
    rx = 1'b1;
    wait_cycles(10);
    check_output("break_no_valid", obs_q.size() - obs_before, 0);
    apply_stimulus("after_break", 8'h3C, CPB, 1'b1, 1'b1, 1'b0, 6);

    // Reset in the middle of bit 4 of 8'h81
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i), CPB);
    drive_bit(1'b0, CPB / 2);
    check_output("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_data", data, 8'h00);
    check_output("midrst_valid", valid, 0);
    check_output("midrst_overrun", overrun, 0);
    check_output("midrst_ferr", frame_err, 0);
    rx = 1'b1;
    wait_cycles(4);
    reset_n = 1'b1;
    wait_cycles(6);
    apply_stimulus("after_rst", 8'h81, CPB, 1'b1, 1'b1, 1'b0, 6);

    // Randomized frames: random byte, rate within +/-3%, occasional bad stop bit
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom);
      rp = int'($urandom_range(101, 107));
      rs = ($urandom_range(0, 7) != 0);
      apply_stimulus($sformatf("rand%0d", i), rb, rp, rs, rs, !rs,
                     rs ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20)));
    end

    wait_cycles(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
